gemm_tile_scheduler: RTL
========================

# gemm_tile_scheduler

Sequences a full GEMM over the 16x16 systolic array by stepping through M, N and K tiles. For each output tile it:
- commands the operand loader to fetch A/B tiles;
- starts the array controller once per K tile, asserting accumulator clear on the first;
- requests write-back of the finished C tile.

It sits above the array controller and the operand/result DMA, and is the only block that issues `arr_start`.

## Interface

Parameters:
- `M_TILES`, 2: output-row tiles (>=1)
- `N_TILES`, 2: output-column tiles (>=1)
- `K_TILES`, 3: reduction tiles (>=1)
- `ADDR_W`, 16: address width
- `A_TILE_WORDS`, 144: words per A tile (16 x BUFFER_SIZE)
- `B_TILE_WORDS`, 144: words per B tile
- `C_TILE_WORDS`, 256: words per C tile

Ports:
- `clk` in 1: clock; all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a GEMM; honoured only in IDLE
- `abort` in 1: synchronous abort, any state
- `busy` out 1: high in every state except IDLE
- `ld_req` out 1: operand load request
- `ld_ack` in 1: load complete
- `ld_a_addr` out ADDR_W: A tile base address
- `ld_b_addr` out ADDR_W: B tile base address
- `arr_start` out 1: one-cycle start pulse to the array controller
- `acc_clear` out 1: qualifies `arr_start`; 1 means the array zeroes its accumulators
- `arr_done` in 1: array finished the current K tile
- `wb_req` out 1: result write-back request
- `wb_ack` in 1: write-back complete
- `wb_addr` out ADDR_W: C tile base address
- `done` out 1: one-cycle pulse when the GEMM completes
- `m_idx`, `n_idx`, `k_idx` out `$clog2(X_TILES)` (min 1 bit): current tile indices

## Operation

States: IDLE, LOAD, FIRE, COMPUTE, WB, FIN.

Transitions:
- IDLE -> LOAD when `start`=1; clears all indices.
- LOAD: `ld_req`=1. Move to FIRE on the cycle `ld_ack`=1.
- FIRE: one cycle with `arr_start`=1 and `acc_clear`=(k_idx==0). Then COMPUTE.
- COMPUTE: wait for `arr_done`=1.
  - If k_idx<K_TILES-1: k_idx+1, go to LOAD.
  - Else: go to WB.
- WB: `wb_req`=1. On `wb_ack`=1, k_idx<=0 and advance the tile:
  - n_idx+1 if n_idx<N_TILES-1;
  - else n_idx<=0 and m_idx+1;
  - go to LOAD.
  - If m_idx==M_TILES-1 and n_idx==N_TILES-1, go to FIN instead.
- FIN: `done`=1 for one cycle, then IDLE.

Loop order is K innermost, then N, then M.

Addresses are combinational from the registered indices, truncated to ADDR_W:
- `ld_a_addr` = (m_idx*K_TILES + k_idx)*A_TILE_WORDS
- `ld_b_addr` = (k_idx*N_TILES + n_idx)*B_TILE_WORDS
- `wb_addr` = (m_idx*N_TILES + n_idx)*C_TILE_WORDS

Rules and boundary conditions:
- Addresses and indices stay stable for as long as the corresponding req is high.
- `ld_ack`, `arr_done` and `wb_ack` are ignored outside LOAD, COMPUTE and WB respectively.
- `start` while busy is ignored.
- `abort`=1 has priority over every other transition:
  - next state is IDLE;
  - all req/pulse outputs drop the following cycle;
  - indices clear;
  - no `done` pulse.
- `acc_clear` is 0 whenever `arr_start` is 0.
- When M_TILES=N_TILES=K_TILES=1, the block performs exactly one load, one fire, one compute and one write-back.

## Timing

- Reset: every output is 0, state is IDLE, and indices are 0.
- All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- `start` sampled high at edge t: `ld_req` and `busy` are high from t+1.
- `ld_ack` high at edge t: `ld_req` low and `arr_start` high at t+1, `arr_start` low at t+2.
- `arr_done` high at edge t: `ld_req` or `wb_req` is high at t+1.
- `wb_ack` on the last tile at edge t: `done` at t+1; `busy` low and IDLE at t+2.
- With ack/done returned in the same cycle as the request, each K step takes 3 cycles and each write-back takes 1 cycle.

## Test plan

- Reset mid-LOAD (`ld_req`=1), then `rst_n`=0 -> all outputs 0 immediately; `start` is required again to resume.
- M=N=1, K=1, immediate acks:
  - `start` at cycle 0 -> `ld_req` at 1;
  - `arr_start`=1 with `acc_clear`=1 at 2;
  - `wb_req` at 4;
  - `done` at 5;
  - `busy` low at 6.
- M=2, N=2, K=3, immediate acks -> exactly 12 `arr_start` pulses, `acc_clear` on pulses 1, 4, 7, 10, and 4 `wb_req` at addresses 0, 256, 512, 768.
- Same config, checking the 5th load (m=0, n=1, k=1):
  - `ld_a_addr`=144;
  - `ld_b_addr`=432.
- Delay `ld_ack` by 10 cycles and raise `arr_done` during LOAD:
  - `ld_req` is held with stable addresses;
  - the spurious `arr_done` is ignored;
  - no extra `arr_start`.
- `abort` asserted in COMPUTE at k_idx=1 -> IDLE next cycle, no `done`. A subsequent `start` restarts at m=n=k=0 with `acc_clear`=1.

Source files
------------

// File: rtl/gemm_tile_scheduler.sv
// Walks the M/N/K tile space of a GEMM on the 16x16 systolic array: loads operands,
// fires the array once per K tile (clearing accumulators on the first) and writes back each C tile.
module gemm_tile_scheduler #(
  parameter int M_TILES      = 2,
  parameter int N_TILES      = 2,
  parameter int K_TILES      = 3,
  parameter int ADDR_W       = 16,
  parameter int A_TILE_WORDS = 144,
  parameter int B_TILE_WORDS = 144,
  parameter int C_TILE_WORDS = 256,
  localparam int MW = (M_TILES > 1) ? $clog2(M_TILES) : 1,
  localparam int NW = (N_TILES > 1) ? $clog2(N_TILES) : 1,
  localparam int KW = (K_TILES > 1) ? $clog2(K_TILES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              ld_req,
  input  logic              ld_ack,
  output logic [ADDR_W-1:0] ld_a_addr,
  output logic [ADDR_W-1:0] ld_b_addr,
  output logic              arr_start,
  output logic              acc_clear,
  input  logic              arr_done,
  output logic              wb_req,
  input  logic              wb_ack,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              done,
  output logic [MW-1:0]     m_idx,
  output logic [NW-1:0]     n_idx,
  output logic [KW-1:0]     k_idx
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    FIRE    = 3'd2,
    COMPUTE = 3'd3,
    WB      = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [MW-1:0] M_LAST = MW'(M_TILES - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_TILES - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K_TILES - 1);

  state_t          state_reg, state_next;
  logic [MW-1:0]   m_reg, m_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [KW-1:0]   k_reg, k_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      n_reg     <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      n_reg     <= n_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    n_next     = n_reg;
    k_next     = k_reg;
    if (abort) begin
      state_next = IDLE;
      m_next     = '0;
      n_next     = '0;
      k_next     = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = LOAD;
            m_next     = '0;
            n_next     = '0;
            k_next     = '0;
          end
        end
        LOAD: begin
          if (ld_ack) state_next = FIRE;
        end
        FIRE: state_next = COMPUTE;
        COMPUTE: begin
          if (arr_done) begin
            if (k_reg < K_LAST) begin
              k_next     = k_reg + KW'(1);
              state_next = LOAD;
            end else begin
              state_next = WB;
            end
          end
        end
        WB: begin
          if (wb_ack) begin
            k_next = '0;
            if (m_reg == M_LAST && n_reg == N_LAST) begin
              state_next = FIN;
            end else begin
              state_next = LOAD;
              if (n_reg < N_LAST) begin
                n_next = n_reg + NW'(1);
              end else begin
                n_next = '0;
                m_next = m_reg + MW'(1);
              end
            end
          end
        end
        FIN:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Every output decodes from registered state only, so no input reaches an output combinationally.
  assign busy      = (state_reg != IDLE);
  assign ld_req    = (state_reg == LOAD);
  assign arr_start = (state_reg == FIRE);
  assign acc_clear = (state_reg == FIRE) && (k_reg == '0);
  assign wb_req    = (state_reg == WB);
  assign done      = (state_reg == FIN);

  assign m_idx = m_reg;
  assign n_idx = n_reg;
  assign k_idx = k_reg;

  // Arithmetic is done modulo 2^ADDR_W, which equals truncating the full-width product.
  assign ld_a_addr = (ADDR_W'(m_reg) * ADDR_W'(K_TILES) + ADDR_W'(k_reg)) * ADDR_W'(A_TILE_WORDS);
  assign ld_b_addr = (ADDR_W'(k_reg) * ADDR_W'(N_TILES) + ADDR_W'(n_reg)) * ADDR_W'(B_TILE_WORDS);
  assign wb_addr   = (ADDR_W'(m_reg) * ADDR_W'(N_TILES) + ADDR_W'(n_reg)) * ADDR_W'(C_TILE_WORDS);

endmodule
